// File: rtl/pc_sequencer.sv
// Program counter sequencer: next-PC selection, EPC capture/restore and a circular return stack.
// Optional target alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [1:0]                     src_sel,
  input  logic [PC_WIDTH-1:0]            branch_tgt,
  input  logic [PC_WIDTH-1:0]            jump_tgt,
  input  logic [PC_WIDTH-1:0]            reg_tgt,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           exc,
  input  logic                           eret,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [PC_WIDTH-1:0]            pc_next_seq,
  output logic [PC_WIDTH-1:0]            epc,
  output logic [PC_WIDTH-1:0]            ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_underflow,
  output logic                           align_err
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] ResetPc = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] ExcPc   = PC_WIDTH'(EXC_VECTOR);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                uf_q, uf_d;
  logic                push;
  logic [PtrW-1:0]     push_idx;
  logic [PC_WIDTH-1:0] tgt;
  logic                ras_empty;

  assign pc_next_seq   = pc_q + PC_WIDTH'(INC);
  assign ras_top       = ras_q[ptr_q];
  assign ras_empty     = (cnt_q == '0);
  assign pc            = pc_q;
  assign epc           = epc_q;
  assign ras_count     = cnt_q;
  assign ras_underflow = uf_q;

`ifdef PC_ALIGN_CHECK_EN
  logic align_q, align_d;
  assign align_err = align_q;
`else
  assign align_err = 1'b0;
`endif

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    uf_d     = uf_q;
    push     = 1'b0;
    push_idx = ptr_q;
    tgt      = '0;
`ifdef PC_ALIGN_CHECK_EN
    align_d  = 1'b0;
`endif
    if (exc) begin
      pc_d  = ExcPc;
      epc_d = pc_q;
    end else if (en) begin
      if (eret) begin
        tgt = epc_q;
      end else if (ret) begin
        tgt = ras_empty ? reg_tgt : ras_top;
      end else begin
        unique case (src_sel)
          2'd0:    tgt = pc_next_seq;
          2'd1:    tgt = branch_tgt;
          2'd2:    tgt = jump_tgt;
          default: tgt = reg_tgt;
        endcase
      end
      pc_d = tgt;

      if (!eret) begin
        if (ret) begin
          if (ras_empty) begin
            uf_d = 1'b1;
          end else if (!call) begin
            ptr_d = ptr_q - PtrOne;
            cnt_d = cnt_q - CntOne;
          end
        end
        if (call) begin
          push = 1'b1;
          // Call+ret on a non-empty stack swaps the top in place.
          if (ret && !ras_empty) begin
            push_idx = ptr_q;
          end else begin
            push_idx = ptr_q + PtrOne;
            ptr_d    = ptr_q + PtrOne;
            cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
          end
        end
      end

`ifdef PC_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        pc_d    = ExcPc;
        epc_d   = tgt;
        align_d = 1'b1;
        push    = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        uf_d    = uf_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= ResetPc;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
`ifdef PC_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
      if (push) begin
        ras_q[push_idx] <= pc_next_seq;
      end
`ifdef PC_ALIGN_CHECK_EN
      align_q <= align_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters (PC_WIDTH=32, RAS_DEPTH=4).
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  src_sel;
  logic [31:0] branch_tgt, jump_tgt, reg_tgt;
  logic        call, ret, exc, eret;
  logic [31:0] pc, pc_next_seq, epc, ras_top;
  logic [2:0]  ras_count;
  logic        ras_underflow, align_err;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .src_sel      (src_sel),
    .branch_tgt   (branch_tgt),
    .jump_tgt     (jump_tgt),
    .reg_tgt      (reg_tgt),
    .call         (call),
    .ret          (ret),
    .exc          (exc),
    .eret         (eret),
    .pc           (pc),
    .pc_next_seq  (pc_next_seq),
    .epc          (epc),
    .ras_top      (ras_top),
    .ras_count    (ras_count),
    .ras_underflow(ras_underflow),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic jump_to(input logic [31:0] a);
    en = 1'b1; src_sel = 2'd2; jump_tgt = a;
    tick();
    src_sel = 2'd0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; src_sel = 2'd0;
    branch_tgt = '0; jump_tgt = '0; reg_tgt = '0;
    call = 1'b0; ret = 1'b0; exc = 1'b0; eret = 1'b0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cnt", 32'(ras_count), 32'd0);
    chk("rst_uf", 32'(ras_underflow), 32'd0);
    chk("rst_align", 32'(align_err), 32'd0);
    chk("rst_top", ras_top, 32'h0);
    rst = 1'b0;

    // Sequential fetch
    en = 1'b1;
    tick(); chk("seq_1", pc, 32'h4);
    tick(); chk("seq_2", pc, 32'h8);
    tick(); chk("seq_3", pc, 32'hC);
    chk("seq_next", pc_next_seq, 32'h10);
    chk("seq_epc", epc, 32'h0);
    chk("seq_cnt", 32'(ras_count), 32'd0);

    // Branch source
    src_sel = 2'd1; branch_tgt = 32'h80;
    tick(); chk("branch", pc, 32'h80);

    // Call then return
    jump_to(32'h100);
    chk("jmp_100", pc, 32'h100);
    call = 1'b1; src_sel = 2'd2; jump_tgt = 32'h400;
    tick(); call = 1'b0;
    chk("call_pc", pc, 32'h400);
    chk("call_cnt", 32'(ras_count), 32'd1);
    chk("call_top", ras_top, 32'h104);
    ret = 1'b1;
    tick(); ret = 1'b0;
    chk("ret_pc", pc, 32'h104);
    chk("ret_cnt", 32'(ras_count), 32'd0);

    // Five calls overflow a 4-deep stack
    jump_to(32'h10);
    call = 1'b1; src_sel = 2'd2;
    jump_tgt = 32'h20; tick();
    jump_tgt = 32'h30; tick();
    jump_tgt = 32'h40; tick();
    jump_tgt = 32'h50; tick();
    chk("push4_cnt", 32'(ras_count), 32'd4);
    jump_tgt = 32'h60; tick();
    call = 1'b0; src_sel = 2'd0;
    chk("push5_cnt", 32'(ras_count), 32'd4);
    chk("push5_top", ras_top, 32'h54);
    ret = 1'b1; reg_tgt = 32'h999C;
    tick(); chk("pop1", pc, 32'h54);
    tick(); chk("pop2", pc, 32'h44);
    tick(); chk("pop3", pc, 32'h34);
    chk("pop3_cnt", 32'(ras_count), 32'd1);
    tick(); chk("pop4", pc, 32'h24);
    chk("pop4_cnt", 32'(ras_count), 32'd0);
    chk("pop4_uf", 32'(ras_underflow), 32'd0);
    tick(); chk("uf_pc", pc, 32'h999C);
    chk("uf_flag", 32'(ras_underflow), 32'd1);
    chk("uf_cnt", 32'(ras_count), 32'd0);
    ret = 1'b0;

    // Exception while stalled, hold, then eret
    jump_to(32'h200);
    en = 1'b0; exc = 1'b1;
    tick(); exc = 1'b0;
    chk("exc_pc", pc, 32'h180);
    chk("exc_epc", epc, 32'h200);
    eret = 1'b1; call = 1'b1;
    tick();
    chk("stall_pc", pc, 32'h180);
    chk("stall_cnt", 32'(ras_count), 32'd0);
    call = 1'b0; en = 1'b1;
    tick(); eret = 1'b0;
    chk("eret_pc", pc, 32'h200);

    // Exception wins over everything
    call = 1'b1; src_sel = 2'd2; jump_tgt = 32'h300;
    tick();
    chk("c2_cnt", 32'(ras_count), 32'd1);
    chk("c2_top", ras_top, 32'h204);
    exc = 1'b1; eret = 1'b1; ret = 1'b1; call = 1'b1;
    tick(); exc = 1'b0; eret = 1'b0;
    chk("prio_pc", pc, 32'h180);
    chk("prio_epc", epc, 32'h300);
    chk("prio_cnt", 32'(ras_count), 32'd1);
    chk("prio_top", ras_top, 32'h204);

    // Call and ret together swap the top
    tick(); ret = 1'b0; call = 1'b0; src_sel = 2'd0;
    chk("swap_pc", pc, 32'h204);
    chk("swap_top", ras_top, 32'h184);
    chk("swap_cnt", 32'(ras_count), 32'd1);
    chk("uf_sticky", 32'(ras_underflow), 32'd1);

    // Address wrap
    jump_to(32'hFFFF_FFFC);
    tick(); chk("wrap", pc, 32'h0);

    // Misaligned register target
    jump_to(32'h500);
    src_sel = 2'd3; reg_tgt = 32'h1002;
    tick(); src_sel = 2'd0; en = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("align_pc", pc, 32'h180);
    chk("align_epc", epc, 32'h1002);
    chk("align_pulse", 32'(align_err), 32'd1);
    tick(); chk("align_clear", 32'(align_err), 32'd0);
`else
    chk("noalign_pc", pc, 32'h1002);
    chk("noalign_err", 32'(align_err), 32'd0);
`endif

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_cnt", 32'(ras_count), 32'd0);
    chk("arst_uf", 32'(ras_underflow), 32'd0);
    chk("arst_top", ras_top, 32'h0);
    chk("arst_epc", epc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the multi-cycle MIPS core.
- Holds the PC and selects the next PC from sequential, branch, jump, register and return-stack sources.
- Captures EPC on exceptions and restores it on ERET.
- Includes a DEPTH-entry circular return-address stack (RAS) for call/return tracking.
- Sits between the control FSM and the instruction memory address port.

Parameters:
- PC_WIDTH, 32, width of PC and all target buses (>= 8).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (truncated to PC_WIDTH).
- EXC_VECTOR, 32'h0000_0180, PC loaded on an exception.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-stack entries (>= 2, power of two).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  PC write enable from the control FSM (a stall is en=0).
- src_sel  input  2  next-PC source: 0 = pc+INC, 1 = branch_tgt, 2 = jump_tgt, 3 = reg_tgt.
- branch_tgt  input  PC_WIDTH  branch target.
- jump_tgt  input  PC_WIDTH  jump target.
- reg_tgt  input  PC_WIDTH  register (JR) target.
- call  input  1  push pc+INC onto the RAS with this update.
- ret  input  1  take the next PC from the RAS top and pop.
- exc  input  1  exception request.
- eret  input  1  return from exception.
- pc  output  PC_WIDTH  current PC.
- pc_next_seq  output  PC_WIDTH  pc+INC, combinational.
- epc  output  PC_WIDTH  exception PC.
- ras_top  output  PC_WIDTH  current RAS top entry, combinational.
- ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_underflow  output  1  sticky flag: ret was issued on an empty RAS.
- align_err  output  1  one-cycle misalignment pulse (optional feature only).

Behaviour:
- Reset is asynchronous, active-high. On reset: pc=RESET_VECTOR, epc=0, ras_count=0, RAS entries=0, ras_underflow=0, align_err=0.
- Every state change happens on a rising clk edge. All updates are single-cycle; the new pc is visible in the cycle after the edge.
- Arithmetic: pc+INC is modulo 2^PC_WIDTH and wraps silently at the top of the address space.
- Priority, highest first: exc > eret > ret > src_sel.
- exc: acts even when en=0.
  - pc <= EXC_VECTOR, epc <= pc.
  - call and ret are ignored; the RAS is unchanged.
- eret (only when en=1 and exc=0): pc <= epc. The RAS is unchanged.
- ret (only when en=1 and exc=0 and eret=0):
  - pc <= ras_top, then pop (ras_count-1).
  - If ras_count=0: pc <= reg_tgt, ras_underflow <= 1 (sticky until reset), count stays 0.
- Normal update (en=1, no exc/eret/ret): pc <= the source chosen by src_sel.
- call (en=1, no exc/eret):
  - Pushes the pre-update pc+INC onto the RAS.
  - When full, the oldest entry is overwritten (circular) and ras_count saturates at RAS_DEPTH.
- call and ret together: pc <= old top, and the top entry is replaced by pc+INC; ras_count is unchanged.
  - If the RAS was empty: pc <= reg_tgt, underflow is set, then the push gives count=1.
- en=0 without exc: pc, epc and the RAS hold; call, ret and eret are ignored.
- Reset mid-operation clears all state immediately, regardless of clk.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: any non-exception update whose selected target has target[1:0] != 0 is replaced by exception entry.
  - pc <= EXC_VECTOR, epc <= the faulting target, align_err=1 for exactly one cycle.
  - The RAS update for that cycle is suppressed.
- Not defined: targets are taken as-is and align_err is tied to 0.

Test Plan:
- Reset release, en=1, src_sel=0 for 3 cycles -> pc = 0x0, 0x4, 0x8, 0xC; epc=0; ras_count=0.
- pc=0x100, call=1, src_sel=2, jump_tgt=0x400; next cycle ret=1 -> pc=0x400 with ras_count=1, ras_top=0x104; then pc=0x104 with ras_count=0.
- RAS_DEPTH=4, five calls at pc 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_count=4, ras_top=0x54; four rets return 0x54, 0x44, 0x34, 0x24; a fifth ret with reg_tgt=0x999C -> pc=0x999C, ras_underflow=1.
- pc=0x200, en=0, exc=1 -> pc=0x180, epc=0x200; then en=1, eret=1 -> pc=0x200.
- pc=0x300, exc=1, eret=1, ret=1, call=1 in the same cycle -> pc=0x180, epc=0x300, ras_count unchanged.
- PC_ALIGN_CHECK_EN defined, pc=0x500, src_sel=3, reg_tgt=0x1002 -> pc=0x180, epc=0x1002, align_err high for one cycle; undefined -> pc=0x1002.
